// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/empty levels, flush,
// sticky overflow/underflow flags and either a fall-through or a registered read port.
module fifo_sync_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FWFT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic [ADDR_W:0]   af_level,
    input  logic [ADDR_W:0]   ae_level,
    input  logic              clr_flags,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_acc;
    logic              wr_acc;
    logic              wr_rej;
    logic              rd_rej;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                     (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign rd_addr = rptr[ADDR_W-1:0];

    // Requests arriving with flush are dropped silently, including for the error flags.
    assign rd_acc = rd & ~empty & ~flush;
    assign wr_acc = wr & (~full | rd_acc) & ~flush;
    assign wr_rej = wr & ~flush & ~wr_acc;
    assign rd_rej = rd & ~flush & ~rd_acc;

    assign almost_full  = (count >= af_level);
    assign almost_empty = (count <= ae_level);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_ONE;
            if (rd_acc) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr[ADDR_W-1:0]] <= din;
    end

    // A new error in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_rej)         overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;
            if (rd_rej)         underflow <= 1'b1;
            else if (clr_flags) underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout       = mem[rd_addr];
            assign dout_valid = ~empty;
        end else begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end else if (flush) begin
                    dout_valid <= 1'b0;
                end else begin
                    dout_valid <= rd_acc;
                    if (rd_acc) dout <= mem[rd_addr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a default FWFT instance (a) and a registered-read 32x8
// instance (b), each checked against queue-based reference models.
module tb_fifo_sync_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       flush_a = 0, wr_a = 0, rd_a = 0, clr_a = 0;
    logic [7:0] din_a = 0, dout_a;
    logic       dv_a, full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a;
    logic [4:0] af_a = 5'd16, ae_a = 5'd0, count_a;

    logic        flush_b = 0, wr_b = 0, rd_b = 0, clr_b = 0;
    logic [31:0] din_b = 0, dout_b;
    logic        dv_b, full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b;
    logic [3:0]  af_b = 4'd8, ae_b = 4'd0, count_b;

    fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .wr(wr_a), .din(din_a), .rd(rd_a),
        .dout(dout_a), .dout_valid(dv_a), .af_level(af_a), .ae_level(ae_a),
        .clr_flags(clr_a), .full(full_a), .empty(empty_a), .almost_full(afull_a),
        .almost_empty(aempty_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a));

    fifo_sync_param #(.DATA_W(32), .ADDR_W(3), .FWFT(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .wr(wr_b), .din(din_b), .rd(rd_b),
        .dout(dout_b), .dout_valid(dv_b), .af_level(af_b), .ae_level(ae_b),
        .clr_flags(clr_b), .full(full_b), .empty(empty_b), .almost_full(afull_b),
        .almost_empty(aempty_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  qa[$];
    logic        m_ovf_a = 0, m_udf_a = 0;
    logic [31:0] qb[$];
    logic        m_ovf_b = 0, m_udf_b = 0, m_dv_b = 0;
    logic [31:0] m_dout_b = 0;

    task automatic clr_models();
        qa.delete(); qb.delete();
        m_ovf_a = 0; m_udf_a = 0; m_ovf_b = 0; m_udf_b = 0; m_dv_b = 0; m_dout_b = 0;
    endtask

    task automatic upd_b(input logic w, input logic r, input logic [31:0] d,
                         input logic f, input logic c);
        bit rok, wok;
        if (f) begin
            qb.delete(); m_dv_b = 0;
            if (c) begin m_ovf_b = 0; m_udf_b = 0; end
        end else begin
            rok = r && qb.size() != 0;
            wok = w && (qb.size() < 8 || rok);
            m_ovf_b = (w && !wok) ? 1'b1 : (c ? 1'b0 : m_ovf_b);
            m_udf_b = (r && !rok) ? 1'b1 : (c ? 1'b0 : m_udf_b);
            m_dv_b = rok;
            if (rok) m_dout_b = qb.pop_front();
            if (wok) qb.push_back(d);
        end
    endtask

    task automatic cyc_a(input logic w, input logic r, input logic [7:0] d,
                         input logic f, input logic c);
        bit rok, wok;
        wr_a = w; rd_a = r; din_a = d; flush_a = f; clr_a = c;
        wr_b = 0; rd_b = 0; flush_b = 0; clr_b = 0;
        if (f) begin
            qa.delete();
            if (c) begin m_ovf_a = 0; m_udf_a = 0; end
        end else begin
            rok = r && qa.size() != 0;
            wok = w && (qa.size() < 16 || rok);
            m_ovf_a = (w && !wok) ? 1'b1 : (c ? 1'b0 : m_ovf_a);
            m_udf_a = (r && !rok) ? 1'b1 : (c ? 1'b0 : m_udf_a);
            if (rok) void'(qa.pop_front());
            if (wok) qa.push_back(d);
        end
        upd_b(0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic cyc_b(input logic w, input logic r, input logic [31:0] d,
                         input logic f, input logic c);
        wr_b = w; rd_b = r; din_b = d; flush_b = f; clr_b = c;
        wr_a = 0; rd_a = 0; flush_a = 0; clr_a = 0;
        upd_b(w, r, d, f, c);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; #2;
        n_tests++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty_a); end
        n_tests++; if (full_a !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full_a); end
        n_tests++; if (count_a !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_a); end
        n_tests++; if (aempty_a !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b want 1", aempty_a); end
        n_tests++; if ({ovf_a, udf_a} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {ovf_a, udf_a}); end
        n_tests++; if ({dv_b, dout_b} !== 33'd0) begin n_fail++; $display("FAIL reset_b_dout got %b/%h want 0/0", dv_b, dout_b); end
        @(posedge clk); #1;
        rst = 0; clr_models();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            cyc_a(1, 0, 8'(i + 1), 0, 0);
            n_tests++; if (count_a !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count got %0d want %0d", count_a, i + 1); end
        end
        n_tests++; if (full_a !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full_a); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (dout_a !== 8'(i + 1)) begin n_fail++; $display("FAIL drain_data got %h want %h", dout_a, 8'(i + 1)); end
            cyc_a(0, 1, 0, 0, 0);
        end
        n_tests++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty_a); end
        n_tests++; if ({ovf_a, udf_a} !== 2'b00) begin n_fail++; $display("FAIL drain_flags got %b want 00", {ovf_a, udf_a}); end
    endtask

    task automatic test_ovf_udf();
        for (int i = 0; i < 16; i++) cyc_a(1, 0, 8'($urandom_range(0, 8'h7F)), 0, 0);
        cyc_a(1, 0, 8'hAA, 0, 0);
        n_tests++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf_a); end
        n_tests++; if (count_a !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", count_a); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (dout_a !== qa[0]) begin n_fail++; $display("FAIL ovf_drain got %h want %h", dout_a, qa[0]); end
            cyc_a(0, 1, 0, 0, 0);
        end
        cyc_a(0, 1, 0, 0, 0);
        n_tests++; if (udf_a !== 1'b1) begin n_fail++; $display("FAIL udf_set got %b want 1", udf_a); end
        cyc_a(0, 0, 0, 0, 1);
        n_tests++; if ({ovf_a, udf_a} !== 2'b00) begin n_fail++; $display("FAIL clr_flags got %b want 00", {ovf_a, udf_a}); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) cyc_a(1, 0, 8'($urandom_range(0, 8'h4F)), 0, 0);
        cyc_a(1, 1, 8'h55, 0, 0);
        n_tests++; if (count_a !== 5'd16) begin n_fail++; $display("FAIL simul_full_count got %0d want 16", count_a); end
        n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL simul_full_ovf got %b want 0", ovf_a); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (dout_a !== qa[0]) begin n_fail++; $display("FAIL simul_drain got %h want %h", dout_a, qa[0]); end
            if (i == 15) begin
                n_tests++; if (dout_a !== 8'h55) begin n_fail++; $display("FAIL simul_last got %h want 55", dout_a); end
            end
            cyc_a(0, 1, 0, 0, 0);
        end
        cyc_a(1, 1, 8'h33, 0, 0);
        n_tests++; if (count_a !== 5'd1) begin n_fail++; $display("FAIL simul_empty_count got %0d want 1", count_a); end
        n_tests++; if (udf_a !== 1'b1) begin n_fail++; $display("FAIL simul_empty_udf got %b want 1", udf_a); end
        n_tests++; if (dout_a !== 8'h33) begin n_fail++; $display("FAIL simul_empty_data got %h want 33", dout_a); end
        cyc_a(0, 1, 0, 0, 1);
    endtask

    task automatic test_thresholds_wrap();
        logic w, r, c;
        af_a = 5'd12; ae_a = 5'd3;
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 99) < ((i % 100) < 50 ? 75 : 30));
            r = ($urandom_range(0, 99) < ((i % 100) < 50 ? 30 : 75));
            c = ($urandom_range(0, 19) == 0);
            cyc_a(w, r, 8'($urandom), 0, c);
            n_tests++; if (count_a !== 5'(qa.size())) begin n_fail++; $display("FAIL wrap_count got %0d want %0d", count_a, qa.size()); end
            n_tests++; if (afull_a !== (qa.size() >= 12)) begin n_fail++; $display("FAIL wrap_afull got %b want %b (n=%0d)", afull_a, qa.size() >= 12, qa.size()); end
            n_tests++; if (aempty_a !== (qa.size() <= 3)) begin n_fail++; $display("FAIL wrap_aempty got %b want %b (n=%0d)", aempty_a, qa.size() <= 3, qa.size()); end
            n_tests++; if ({full_a, empty_a} !== {qa.size() == 16, qa.size() == 0}) begin n_fail++; $display("FAIL wrap_full_empty got %b%b n=%0d", full_a, empty_a, qa.size()); end
            n_tests++; if ({ovf_a, udf_a} !== {m_ovf_a, m_udf_a}) begin n_fail++; $display("FAIL wrap_flags got %b want %b", {ovf_a, udf_a}, {m_ovf_a, m_udf_a}); end
            if (qa.size() != 0) begin
                n_tests++; if (dout_a !== qa[0] || dv_a !== 1'b1) begin n_fail++; $display("FAIL wrap_data got %h/%b want %h/1", dout_a, dv_a, qa[0]); end
            end
        end
        af_a = 5'd0; #1;
        n_tests++; if (afull_a !== 1'b1) begin n_fail++; $display("FAIL af_zero got %b want 1", afull_a); end
        for (int i = 0; i < 20; i++) cyc_a(1, 0, 8'($urandom), 0, 0);
        ae_a = 5'd16; #1;
        n_tests++; if (aempty_a !== 1'b1) begin n_fail++; $display("FAIL ae_depth got %b want 1", aempty_a); end
        ae_a = 5'd20; #1;
        n_tests++; if (aempty_a !== 1'b1) begin n_fail++; $display("FAIL ae_over got %b want 1", aempty_a); end
        ae_a = 5'd15; #1;
        n_tests++; if (aempty_a !== 1'b0) begin n_fail++; $display("FAIL ae_below got %b want 0", aempty_a); end
        af_a = 5'd16; ae_a = 5'd0;
        cyc_a(0, 0, 0, 1, 1);
    endtask

    task automatic test_fwft0();
        logic w, r;
        cyc_b(1, 0, 32'hDEADBEEF, 0, 0);
        n_tests++; if (dv_b !== 1'b0) begin n_fail++; $display("FAIL b_wr_dv got %b want 0", dv_b); end
        cyc_b(0, 1, 0, 0, 0);
        n_tests++; if (dv_b !== 1'b1 || dout_b !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b_rd got %b/%h want 1/deadbeef", dv_b, dout_b); end
        cyc_b(0, 0, 0, 0, 0);
        n_tests++; if (dv_b !== 1'b0 || dout_b !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b_hold got %b/%h want 0/deadbeef", dv_b, dout_b); end
        for (int i = 0; i < 8; i++) cyc_b(1, 0, $urandom, 0, 0);
        n_tests++; if (full_b !== 1'b1 || count_b !== 4'd8) begin n_fail++; $display("FAIL b_full got %b/%0d want 1/8", full_b, count_b); end
        af_b = 4'd6; ae_b = 4'd2;
        for (int i = 0; i < 200; i++) begin
            w = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            cyc_b(w, r, $urandom, 0, ($urandom_range(0, 15) == 0));
            n_tests++; if (dv_b !== m_dv_b || dout_b !== m_dout_b) begin n_fail++; $display("FAIL b_rand_data got %b/%h want %b/%h", dv_b, dout_b, m_dv_b, m_dout_b); end
            n_tests++; if (count_b !== 4'(qb.size())) begin n_fail++; $display("FAIL b_rand_count got %0d want %0d", count_b, qb.size()); end
            n_tests++; if ({afull_b, aempty_b} !== {qb.size() >= 6, qb.size() <= 2}) begin n_fail++; $display("FAIL b_rand_levels got %b%b n=%0d", afull_b, aempty_b, qb.size()); end
            n_tests++; if ({ovf_b, udf_b} !== {m_ovf_b, m_udf_b}) begin n_fail++; $display("FAIL b_rand_flags got %b want %b", {ovf_b, udf_b}, {m_ovf_b, m_udf_b}); end
        end
        af_b = 4'd8; ae_b = 4'd0;
    endtask

    task automatic test_flush();
        cyc_a(0, 0, 0, 0, 1);
        cyc_a(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc_a(1, 0, 8'($urandom), 0, 0);
        n_tests++; if (count_a !== 5'd5) begin n_fail++; $display("FAIL flush_pre got %0d want 5", count_a); end
        cyc_a(1, 1, 8'h99, 1, 0);
        n_tests++; if (count_a !== 5'd0 || empty_a !== 1'b1) begin n_fail++; $display("FAIL flush_clear got %0d/%b want 0/1", count_a, empty_a); end
        n_tests++; if ({ovf_a, udf_a} !== 2'b01) begin n_fail++; $display("FAIL flush_flags got %b want 01", {ovf_a, udf_a}); end
        cyc_a(1, 0, 8'h77, 0, 0);
        n_tests++; if (dout_a !== 8'h77 || count_a !== 5'd1) begin n_fail++; $display("FAIL flush_after got %h/%0d want 77/1", dout_a, count_a); end
        cyc_b(1, 0, 32'h1234_5678, 0, 0);
        cyc_b(1, 0, 32'h9ABC_DEF0, 0, 0);
        cyc_b(0, 1, 0, 0, 0);
        cyc_b(0, 1, 0, 1, 0);
        n_tests++; if (dv_b !== 1'b0 || empty_b !== 1'b1) begin n_fail++; $display("FAIL flush_b got %b/%b want 0/1", dv_b, empty_b); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 17; i++) cyc_a(1, 0, 8'($urandom), 0, 0);
        cyc_b(1, 0, 32'hCAFE_F00D, 0, 0);
        cyc_b(1, 0, 32'h0BAD_BEEF, 0, 0);
        cyc_b(0, 1, 0, 0, 0);
        n_tests++; if (ovf_a !== 1'b1 || dv_b !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %b/%b want 1/1", ovf_a, dv_b); end
        #3 rst = 1;
        #1;
        n_tests++; if (count_a !== 5'd0 || empty_a !== 1'b1 || full_a !== 1'b0) begin n_fail++; $display("FAIL arst_a got %0d/%b/%b want 0/1/0", count_a, empty_a, full_a); end
        n_tests++; if ({ovf_a, udf_a} !== 2'b00) begin n_fail++; $display("FAIL arst_flags got %b want 00", {ovf_a, udf_a}); end
        n_tests++; if (dv_b !== 1'b0 || dout_b !== 32'd0 || count_b !== 4'd0) begin n_fail++; $display("FAIL arst_b got %b/%h/%0d want 0/0/0", dv_b, dout_b, count_b); end
        wr_a = 0; rd_a = 0; wr_b = 0; rd_b = 0;
        @(posedge clk); #1;
        rst = 0; clr_models();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_ovf_udf();
        test_simultaneous();
        test_thresholds_wrap();
        test_fwft0();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
